// File: rtl/nor_latch.sv
// Clocked model of a bank of cross-coupled NOR set/reset latches with a deterministic forbidden state.
// Optional build macro NOR_LATCH_SYNC_INPUTS_EN adds a 2-flop synchronizer on set/reset.
module nor_latch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  output logic [WIDTH-1:0] invalid
);

  typedef enum logic [1:0] {
    ST_CLR    = 2'b00,
    ST_SET    = 2'b01,
    ST_FORBID = 2'b10
  } state_e;

  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] reset_s;

`ifdef NOR_LATCH_SYNC_INPUTS_EN
  logic [WIDTH-1:0] set_meta_r;
  logic [WIDTH-1:0] set_sync_r;
  logic [WIDTH-1:0] reset_meta_r;
  logic [WIDTH-1:0] reset_sync_r;

  // Two-flop synchronizer on both request buses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_meta_r   <= '0;
      set_sync_r   <= '0;
      reset_meta_r <= '0;
      reset_sync_r <= '0;
    end else begin
      set_meta_r   <= set;
      set_sync_r   <= set_meta_r;
      reset_meta_r <= reset;
      reset_sync_r <= reset_meta_r;
    end
  end

  assign set_s   = set_sync_r;
  assign reset_s = reset_sync_r;
`else
  assign set_s   = set;
  assign reset_s = reset;
`endif

  state_e           state_r     [WIDTH];
  state_e           state_nxt_s [WIDTH];
  logic [WIDTH-1:0] o1_r;
  logic [WIDTH-1:0] o2_r;
  logic [WIDTH-1:0] invalid_r;

  // Per-bit next-state: any request wins; idle resolves FORBID (or any stray code) to CLR
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt_s[i] = state_r[i];
      case ({set_s[i], reset_s[i]})
        2'b10:   state_nxt_s[i] = ST_SET;
        2'b01:   state_nxt_s[i] = ST_CLR;
        2'b11:   state_nxt_s[i] = ST_FORBID;
        default: begin
          case (state_r[i])
            ST_SET:  state_nxt_s[i] = ST_SET;
            default: state_nxt_s[i] = ST_CLR;
          endcase
        end
      endcase
    end
  end

  // State and output registers; outputs decoded from next state so they carry no extra latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= ST_CLR;
      end
      o1_r      <= '0;
      o2_r      <= '1;
      invalid_r <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i]   <= state_nxt_s[i];
        o1_r[i]      <= (state_nxt_s[i] == ST_SET)    ? 1'b1 : 1'b0;
        o2_r[i]      <= (state_nxt_s[i] == ST_CLR)    ? 1'b1 : 1'b0;
        invalid_r[i] <= (state_nxt_s[i] == ST_FORBID) ? 1'b1 : 1'b0;
      end
    end
  end

  assign o1      = o1_r;
  assign o2      = o2_r;
  assign invalid = invalid_r;

endmodule

// File: tb/tb_nor_latch.sv
// Self-checking bench for nor_latch (WIDTH=4): vector table, hand sequences, randomized model compare.
module tb_nor_latch;

`ifdef NOR_LATCH_SYNC_INPUTS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] set;
  logic [3:0] reset;
  logic [3:0] o1;
  logic [3:0] o2;
  logic [3:0] invalid;

  int errors = 0;
  int checks = 0;

  nor_latch #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .o1      (o1),
    .o2      (o2),
    .set     (set),
    .reset   (reset),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] o1;
    logic [3:0] o2;
    logic [3:0] inv;
    int         hold;
  } vec_t;

  vec_t tbl [17];

  // reference model: latch value per bit plus forbidden flag, fed by delayed inputs
  logic [3:0] m_q;
  logic [3:0] m_forb;
  logic [3:0] hist_s [3];
  logic [3:0] hist_r [3];

  task automatic check(input string name, input logic [3:0] e1, input logic [3:0] e2,
                       input logic [3:0] ei);
    checks++;
    if ({o1, o2, invalid} !== {e1, e2, ei}) begin
      errors++;
      $display("FAIL %s: got o1=%b o2=%b inv=%b, want o1=%b o2=%b inv=%b",
               name, o1, o2, invalid, e1, e2, ei);
    end
  endtask

  task automatic model_reset();
    m_q    = 4'b0000;
    m_forb = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      hist_s[k] = 4'b0000;
      hist_r[k] = 4'b0000;
    end
  endtask

  task automatic model_edge();
    logic [3:0] s;
    logic [3:0] r;
    hist_s[2] = hist_s[1];
    hist_r[2] = hist_r[1];
    hist_s[1] = hist_s[0];
    hist_r[1] = hist_r[0];
    hist_s[0] = set;
    hist_r[0] = reset;
    s = hist_s[LAT-1];
    r = hist_r[LAT-1];
    m_forb = s & r;
    m_q    = (s & ~r) | (m_q & ~s & ~r);
  endtask

  initial begin
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] pi;

    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 10};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 10};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 10};
    tbl[3]  = '{4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 10};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 10};
    tbl[5]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 1};
    tbl[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 1};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 3};
    tbl[8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 1};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 1};
    tbl[10] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0000, 1};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 4};
    tbl[12] = '{4'b1000, 4'b1000, 4'b0101, 4'b0010, 4'b1000, 1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 2};
    tbl[14] = '{4'b0110, 4'b1001, 4'b0110, 4'b1001, 4'b0000, 1};
    tbl[15] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 2};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 2};

    // asynchronous reset with a set request pending
    rst_n = 1'b1;
    set   = 4'b0001;
    reset = 4'b0000;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 4'b0000, 4'b1111, 4'b0000);
    repeat (2) @(posedge clk);
    #1 check("reset_hold_with_set", 4'b0000, 4'b1111, 4'b0000);
    @(negedge clk);
    set   = 4'b0000;
    rst_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1 check("reset_release_idle", 4'b0000, 4'b1111, 4'b0000);

    // table: output must not move before LAT edges, must match after LAT, and after holding
    p1 = 4'b0000;
    p2 = 4'b1111;
    pi = 4'b0000;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      set   = tbl[i].s;
      reset = tbl[i].r;
      repeat (LAT - 1) @(posedge clk);
      #1 check($sformatf("vec%0d_before", i), p1, p2, pi);
      @(posedge clk);
      #1 check($sformatf("vec%0d_after", i), tbl[i].o1, tbl[i].o2, tbl[i].inv);
      if (tbl[i].hold > 1) begin
        repeat (tbl[i].hold - 1) @(posedge clk);
        #1 check($sformatf("vec%0d_held", i), tbl[i].o1, tbl[i].o2, tbl[i].inv);
      end
      p1 = tbl[i].o1;
      p2 = tbl[i].o2;
      pi = tbl[i].inv;
    end

    // single-cycle set pulse on bit 0: rises exactly LAT edges after it is applied
    @(negedge clk);
    set   = 4'b0001;
    reset = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k >= LAT) check($sformatf("pulse_edge%0d", k), 4'b0001, 4'b1110, 4'b0000);
      else          check($sformatf("pulse_edge%0d", k), 4'b0000, 4'b1111, 4'b0000);
      @(negedge clk);
      set = 4'b0000;
    end

    // reset asserted between edges while in SET
    #2 rst_n = 1'b0;
    #1 check("midop_reset", 4'b0000, 4'b1111, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    set   = 4'b0000;
    reset = 4'b0000;
    repeat (LAT + 2) @(posedge clk);
    #1 check("midop_release_idle", 4'b0000, 4'b1111, 4'b0000);

    // randomized traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    set   = 4'b0000;
    reset = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      set   = 4'($urandom) & 4'($urandom);
      reset = 4'($urandom) & 4'($urandom);
      @(posedge clk);
      model_edge();
      #1 check($sformatf("rand%0d", n), m_q, ~m_q & ~m_forb, m_forb);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
